// File: rtl/prog_cntr_stack.sv
// prog_cntr_stack: fetch-path program counter with load, relative branch, call/return stack and wrap pulse
module prog_cntr_stack #(
    parameter int WIDTH = 8,
    parameter int STACK_DEPTH = 4,
    parameter int SP_W = 3,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_offset,
    input  logic             i_count_en,
    input  logic             i_load,
    input  logic             i_branch,
    input  logic             i_call,
    input  logic             i_ret,
    output logic [WIDTH-1:0] o_y,
    output logic             o_wrap,
    output logic [SP_W-1:0]  o_depth,
    output logic             o_stack_full,
    output logic             o_stack_empty,
    output logic             o_stack_err
);
    // sized to the full SP_W index range so Depth addresses it directly
    logic [WIDTH-1:0] r_stack [2**SP_W];
    logic [WIDTH-1:0] r_y;
    logic [SP_W-1:0]  r_depth;
    logic             r_wrap;
    logic             r_err;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_top;
    logic             w_full;
    logic             w_empty;

    assign w_inc   = r_y + WIDTH'(1);
    assign w_top   = r_stack[r_depth - SP_W'(1)];
    assign w_full  = r_depth == SP_W'(STACK_DEPTH);
    assign w_empty = r_depth == '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_y     <= RESET_VECTOR;
            r_depth <= '0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_load) begin
                r_y <= i_a;
            end else if (i_ret) begin
                if (w_empty) begin
                    r_err <= 1'b1;
                end else begin
                    r_y     <= w_top;
                    r_depth <= r_depth - SP_W'(1);
                end
            end else if (i_call) begin
                if (w_full) begin
                    r_err <= 1'b1;
                end else begin
                    r_stack[r_depth] <= w_inc;
                    r_depth          <= r_depth + SP_W'(1);
                    r_y              <= i_a;
                end
            end else if (i_branch) begin
                r_y <= r_y + i_offset;
            end else if (i_count_en) begin
                r_y    <= w_inc;
                r_wrap <= &r_y;
            end
        end
    end

    assign o_y           = r_y;
    assign o_wrap        = r_wrap;
    assign o_depth       = r_depth;
    assign o_stack_full  = w_full;
    assign o_stack_empty = w_empty;
    assign o_stack_err   = r_err;
endmodule

// File: tb/tb_prog_cntr_stack.sv
// tb_prog_cntr_stack: directed commands push expected PC/stack state; a monitor pops and compares each cycle
module tb_prog_cntr_stack;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] offset = '0;
    logic       count_en = 1'b0;
    logic       load = 1'b0;
    logic       branch = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [7:0] y;
    logic       wrap;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       err;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] y;
        logic       w;
        logic [2:0] d;
        logic       e;
        string      nm;
    } exp_t;
    exp_t q[$];

    prog_cntr_stack #(.WIDTH(8), .STACK_DEPTH(4), .SP_W(3), .RESET_VECTOR(8'h10)) dut (
        .i_clk(clk), .i_reset(reset), .i_a(a), .i_offset(offset),
        .i_count_en(count_en), .i_load(load), .i_branch(branch),
        .i_call(call), .i_ret(ret), .o_y(y), .o_wrap(wrap), .o_depth(depth),
        .o_stack_full(full), .o_stack_empty(empty), .o_stack_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk({e.nm, ".y"}, y, e.y);
                chk({e.nm, ".wrap"}, {7'b0, wrap}, {7'b0, e.w});
                chk({e.nm, ".depth"}, {5'b0, depth}, {5'b0, e.d});
                chk({e.nm, ".full"}, {7'b0, full}, {7'b0, e.d == 3'd4});
                chk({e.nm, ".empty"}, {7'b0, empty}, {7'b0, e.d == 3'd0});
                chk({e.nm, ".err"}, {7'b0, err}, {7'b0, e.e});
            end
        end
    end

    // cmd bits: {reset, load, ret, call, branch, count_en}
    task automatic cmd(input logic [5:0] c, input logic [7:0] ta, input logic [7:0] toff,
                       input logic [7:0] ey, input logic ew, input logic [2:0] ed,
                       input logic ee, input string nm);
        {reset, load, ret, call, branch, count_en} = c;
        a = ta;
        offset = toff;
        q.push_back('{ey, ew, ed, ee, nm});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        cmd(6'b100000, 8'h00, 8'h00, 8'h10, 0, 3'd0, 0, "reset");
        cmd(6'b000001, 8'h00, 8'h00, 8'h11, 0, 3'd0, 0, "inc1");
        cmd(6'b000001, 8'h00, 8'h00, 8'h12, 0, 3'd0, 0, "inc2");
        cmd(6'b000001, 8'h00, 8'h00, 8'h13, 0, 3'd0, 0, "inc3");
        cmd(6'b010000, 8'hFE, 8'h00, 8'hFE, 0, 3'd0, 0, "load_fe");
        cmd(6'b000001, 8'h00, 8'h00, 8'hFF, 0, 3'd0, 0, "inc_ff");
        cmd(6'b000001, 8'h00, 8'h00, 8'h00, 1, 3'd0, 0, "inc_wrap");
        cmd(6'b000001, 8'h00, 8'h00, 8'h01, 0, 3'd0, 0, "inc_01");
        cmd(6'b000000, 8'h77, 8'h00, 8'h01, 0, 3'd0, 0, "idle_hold");
        cmd(6'b010000, 8'h20, 8'h00, 8'h20, 0, 3'd0, 0, "load_20");
        cmd(6'b000010, 8'h00, 8'hF0, 8'h10, 0, 3'd0, 0, "br_neg16");
        cmd(6'b000010, 8'h00, 8'h05, 8'h15, 0, 3'd0, 0, "br_pos5");
        cmd(6'b010000, 8'hFF, 8'h00, 8'hFF, 0, 3'd0, 0, "load_ff");
        cmd(6'b000010, 8'h00, 8'h01, 8'h00, 0, 3'd0, 0, "br_nowrap");
        cmd(6'b010000, 8'h40, 8'h00, 8'h40, 0, 3'd0, 0, "load_40");
        cmd(6'b000100, 8'h80, 8'h00, 8'h80, 0, 3'd1, 0, "call_80");
        cmd(6'b000100, 8'h90, 8'h00, 8'h90, 0, 3'd2, 0, "call_90");
        cmd(6'b000100, 8'hA0, 8'h00, 8'hA0, 0, 3'd3, 0, "call_a0");
        cmd(6'b000100, 8'hB0, 8'h00, 8'hB0, 0, 3'd4, 0, "call_b0");
        cmd(6'b000100, 8'hC0, 8'h00, 8'hB0, 0, 3'd4, 1, "call_full");
        cmd(6'b001000, 8'h00, 8'h00, 8'hA1, 0, 3'd3, 1, "ret_a1");
        cmd(6'b001000, 8'h00, 8'h00, 8'h91, 0, 3'd2, 1, "ret_91");
        cmd(6'b001000, 8'h00, 8'h00, 8'h81, 0, 3'd1, 1, "ret_81");
        cmd(6'b001000, 8'h00, 8'h00, 8'h41, 0, 3'd0, 1, "ret_41");
        cmd(6'b001000, 8'h00, 8'h00, 8'h41, 0, 3'd0, 1, "ret_empty");
        cmd(6'b000001, 8'h00, 8'h00, 8'h42, 0, 3'd0, 1, "err_sticky");
        cmd(6'b000100, 8'h50, 8'h00, 8'h50, 0, 3'd1, 1, "call_50");
        cmd(6'b000100, 8'h60, 8'h00, 8'h60, 0, 3'd2, 1, "call_60");
        cmd(6'b011001, 8'h70, 8'h00, 8'h70, 0, 3'd2, 1, "load_wins");
        cmd(6'b001000, 8'h00, 8'h00, 8'h51, 0, 3'd1, 1, "ret_51");
        cmd(6'b001101, 8'h99, 8'h00, 8'h43, 0, 3'd0, 1, "ret_over_call");
        cmd(6'b000111, 8'h30, 8'h03, 8'h30, 0, 3'd1, 1, "call_over_br");
        cmd(6'b000011, 8'h00, 8'h02, 8'h32, 0, 3'd1, 1, "br_over_inc");
        cmd(6'b100101, 8'h99, 8'h00, 8'h10, 0, 3'd0, 0, "reset_call");
        cmd(6'b000000, 8'h00, 8'h00, 8'h10, 0, 3'd0, 0, "post_reset");
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prog_cntr_stack.md
Name: prog_cntr_stack

Overview:
Parametrised program counter. Successor to the fixed 8-bit loadable counter, extended with:
- configurable width and reset vector
- PC-relative branch
- hardware call/return stack with overflow/underflow detection
- wrap indication

Sits in the fetch path and drives the instruction memory address. One clock domain; fully synchronous.

Parameters:
WIDTH, 8, PC and address width in bits (≥2)
STACK_DEPTH, 4, number of return-address entries (≥1)
SP_W, 3, width of the Depth output; must satisfy 2^SP_W > STACK_DEPTH
RESET_VECTOR, 0, value loaded into Y on reset (WIDTH bits)

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
A  input  WIDTH  absolute target for Load and Call
Offset  input  WIDTH  two's-complement branch displacement
CountEn  input  1  increment enable
Load  input  1  absolute jump
Branch  input  1  relative jump
Call  input  1  push return address, jump to A
Ret  input  1  pop return address into Y
Y  output  WIDTH  current PC, registered
Wrap  output  1  one-cycle pulse on increment from all-ones to zero
Depth  output  SP_W  number of valid stack entries
StackFull  output  1  Depth == STACK_DEPTH
StackEmpty  output  1  Depth == 0
StackErr  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (sampled at rising Clk), all registered outputs:
  - Y=RESET_VECTOR, Depth=0, Wrap=0, StackErr=0
  - Stack contents don't-care
  - Reset overrides every command in the same cycle, including mid-call sequences.
- Command priority per cycle, highest first: Reset > Load > Ret > Call > Branch > CountEn. Exactly one action per cycle; lower-priority requests in the same cycle are discarded, not queued.
- Load: Y<=A. Stack untouched.
- Ret:
  - If Depth>0: Y<=top entry, Depth<=Depth-1.
  - If Depth==0: Y holds, Depth holds, StackErr<=1.
- Call:
  - If Depth<STACK_DEPTH: push (Y+1) mod 2^WIDTH, Depth<=Depth+1, Y<=A.
  - If full: whole call is suppressed (Y holds, no push), StackErr<=1.
- Branch: Y<=(Y+Offset) mod 2^WIDTH, sign-extended arithmetic, no Wrap pulse.
- CountEn alone: Y<=(Y+1) mod 2^WIDTH.
  - If Y was all-ones, Wrap=1 for exactly the next cycle; Wrap is 0 otherwise.
- No command asserted: Y holds.
- Load, Ret, Call and Branch act regardless of CountEn.
- Latency: every command is visible on Y one cycle after the sampling edge.
- Stack is LIFO, indexed by Depth. Pop reads entry Depth-1 combinationally before the edge.
- StackFull and StackEmpty are combinational decodes of registered Depth.
- StackErr clears only on Reset.
- No asynchronous paths. Y is never updated on the falling edge.

Test Plan:
- Reset with RESET_VECTOR=8'h10, then CountEn=1 for 3 cycles → Y=10,11,12,13; Depth=0, StackEmpty=1, Wrap=0.
- Load A=8'hFE, then CountEn for 3 cycles → Y=FE,FF,00,01; Wrap=1 only in the cycle Y=00.
- Y=8'h20, Branch Offset=8'hF0 (−16) → Y=10. Then Offset=8'h05 → Y=15. No Wrap.
- From Y=8'h40, four Calls to A=80,90,A0,B0 → Depth=4, StackFull=1. Then four Rets → Y=A1,91,81,41, Depth=0.
- Fifth Call at full (A=8'hC0) → Y holds, Depth=4, StackErr=1. Then Ret from empty → Y holds, StackErr stays 1 until Reset.
- Load+Ret+CountEn in the same cycle with Depth=2 → Load wins, Depth stays 2. Reset asserted together with Call → Y=RESET_VECTOR, Depth=0, StackErr=0.
